// File: rtl/alu_unit_if.sv
// rtl/alu_unit_if.sv - issue/result bundle between the control unit and the datapath ALU
interface alu_unit_if #(
    parameter int WIDTH = 16
);
    logic [2:0]       alu_op;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic [WIDTH-1:0] result;
    logic             z;
    logic             busy;
    logic             done;

    modport master (
        output alu_op, a_in, b_in,
        input  result, z, busy, done
    );

    modport slave (
        input  alu_op, a_in, b_in,
        output result, z, busy, done
    );
endinterface

// File: rtl/alu_unit.sv
// rtl/alu_unit.sv - datapath ALU: single-cycle add/sub/lshift, iterative shift-add multiply
module alu_unit #(
    parameter int WIDTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    alu_unit_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [2:0] OP_NONE   = 3'd0;
    localparam logic [2:0] OP_ADD    = 3'd1;
    localparam logic [2:0] OP_SUB    = 3'd2;
    localparam logic [2:0] OP_MULT   = 3'd3;
    localparam logic [2:0] OP_LSHIFT = 3'd4;

    typedef enum logic {IDLE, MUL} state_e;

    state_e           state_q, state_d;
    logic [2:0]       prev_op_q, prev_op_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             z_q, z_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             accept;
    logic [WIDTH-1:0] op_res;
    logic [WIDTH-1:0] acc_step;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            prev_op_q <= OP_NONE;
            cnt_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            result_q  <= '0;
            z_q       <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            prev_op_q <= prev_op_d;
            cnt_q     <= cnt_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            result_q  <= result_d;
            z_q       <= z_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // An op fires only on the 0 -> nonzero transition of alu_op, so a held code runs once.
    assign accept = (state_q == IDLE) && (bus.alu_op >= OP_ADD) &&
                    (bus.alu_op <= OP_LSHIFT) && (prev_op_q == OP_NONE);

    assign acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

    always_comb begin
        state_d   = state_q;
        prev_op_d = bus.alu_op;
        cnt_d     = cnt_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        result_d  = result_q;
        z_d       = z_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        op_res    = '0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (bus.alu_op == OP_MULT) begin
                        mcand_d  = bus.a_in;
                        mplier_d = bus.b_in;
                        acc_d    = '0;
                        cnt_d    = '0;
                        busy_d   = 1'b1;
                        state_d  = MUL;
                    end else begin
                        case (bus.alu_op)
                            OP_ADD:  op_res = bus.a_in + bus.b_in;
                            OP_SUB:  op_res = bus.a_in - bus.b_in;
                            default: op_res = {bus.a_in[WIDTH-2:0], 1'b0};
                        endcase
                        result_d = op_res;
                        z_d      = (op_res == '0);
                        done_d   = 1'b1;
                    end
                end
            end
            MUL: begin
                acc_d    = acc_step;
                mcand_d  = {mcand_q[WIDTH-2:0], 1'b0};
                mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
                cnt_d    = cnt_q + CW'(1);
                // Fixed latency: the WIDTH-th iteration retires the product.
                if (cnt_q == CW'(WIDTH - 1)) begin
                    result_d = acc_step;
                    z_d      = (acc_step == '0);
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.result = result_q;
    assign bus.z      = z_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
endmodule

// File: tb/tb_alu_unit.sv
// tb/tb_alu_unit.sv - directed and randomized checks of alu_unit against an arithmetic model
module tb_alu_unit;
    logic clk;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;

    logic [15:0] exp_res;
    logic        exp_z;

    alu_unit_if #(.WIDTH(16)) bus ();

    alu_unit #(.WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model(input logic [2:0] op, input logic [15:0] a,
                                          input logic [15:0] b);
        logic [31:0] p;
        case (op)
            3'd1:    p = 32'(a) + 32'(b);
            3'd2:    p = 32'(a) - 32'(b);
            3'd3:    p = 32'(a) * 32'(b);
            default: p = 32'(a) * 32'd2;
        endcase
        return p[15:0];
    endfunction

    // Called on a falling edge; returns on a falling edge with alu_op back at 0.
    task automatic do_single(input logic [2:0] op, input logic [15:0] a,
                             input logic [15:0] b, input string tag);
        exp_res = model(op, a, b);
        exp_z   = (exp_res == 16'h0);
        bus.alu_op = op;
        bus.a_in   = a;
        bus.b_in   = b;
        @(negedge clk);
        bus.alu_op = 3'd0;
        bus.a_in   = 16'($urandom);
        check({tag, ".done"},   32'(bus.done),   32'd1);
        check({tag, ".result"}, 32'(bus.result), 32'(exp_res));
        check({tag, ".z"},      32'(bus.z),      32'(exp_z));
        @(negedge clk);
        check({tag, ".done_off"}, 32'(bus.done), 32'd0);
    endtask

    task automatic do_mult(input logic [15:0] a, input logic [15:0] b,
                           input int intr, input string tag);
        logic [15:0] hold_res;
        logic        hold_z;
        int          e;
        hold_res   = exp_res;
        hold_z     = exp_z;
        bus.alu_op = 3'd3;
        bus.a_in   = a;
        bus.b_in   = b;
        @(negedge clk);
        bus.a_in = 16'($urandom);
        bus.b_in = 16'($urandom);
        check({tag, ".busy"},      32'(bus.busy),   32'd1);
        check({tag, ".hold_res"},  32'(bus.result), 32'(hold_res));
        check({tag, ".hold_z"},    32'(bus.z),      32'(hold_z));
        e = 0;
        while (bus.busy === 1'b1 && e < 40) begin
            bus.alu_op = (e == intr) ? 3'd1 : 3'd0;
            check({tag, ".done_busy"}, 32'(bus.done), 32'd0);
            @(negedge clk);
            e++;
        end
        bus.alu_op = 3'd0;
        exp_res = model(3'd3, a, b);
        exp_z   = (exp_res == 16'h0);
        check({tag, ".latency"}, 32'(e),          32'd16);
        check({tag, ".done"},    32'(bus.done),   32'd1);
        check({tag, ".result"},  32'(bus.result), 32'(exp_res));
        check({tag, ".z"},       32'(bus.z),      32'(exp_z));
        @(negedge clk);
        check({tag, ".done_off"}, 32'(bus.done), 32'd0);
    endtask

    initial begin
        logic [2:0]  rop;
        logic [15:0] ra;
        logic [15:0] rb;

        rst        = 1'b1;
        bus.alu_op = 3'd0;
        bus.a_in   = 16'h0;
        bus.b_in   = 16'h0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_res = 16'h0;
        exp_z   = 1'b1;
        check("reset.result", 32'(bus.result), 32'h0);
        check("reset.z",      32'(bus.z),      32'd1);
        check("reset.busy",   32'(bus.busy),   32'd0);
        check("reset.done",   32'(bus.done),   32'd0);

        do_single(3'd1, 16'h7FFF, 16'h0001, "add_ovf");
        do_single(3'd1, 16'hFFFF, 16'h0001, "add_wrap");
        do_single(3'd2, 16'd5, 16'd5, "sub_zero");
        do_single(3'd2, 16'd3, 16'd5, "sub_neg");
        do_single(3'd4, 16'h8001, 16'h1234, "lshift");
        do_mult(16'd300, 16'd300, -1, "mult_300");
        do_mult(16'hFFFF, 16'hFFFF, -1, "mult_ffff");
        do_mult(16'h0100, 16'h0100, -1, "mult_zero");
        do_mult(16'd1234, 16'd7, 3, "mult_intr");

        // Held op: one execution using operands sampled at the accepting edge.
        bus.alu_op = 3'd1;
        bus.a_in   = 16'd10;
        bus.b_in   = 16'd20;
        @(negedge clk);
        bus.a_in = 16'd100;
        check("held.done",   32'(bus.done),   32'd1);
        check("held.result", 32'(bus.result), 32'd30);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("held.done_again", 32'(bus.done),   32'd0);
            check("held.result_hold", 32'(bus.result), 32'd30);
        end
        bus.alu_op = 3'd0;
        @(negedge clk);
        exp_res = 16'd30;
        exp_z   = 1'b0;

        // Codes 5-7 are no-ops.
        for (int c = 5; c < 8; c++) begin
            bus.alu_op = 3'(c);
            @(negedge clk);
            bus.alu_op = 3'd0;
            check("noop.done",   32'(bus.done),   32'd0);
            check("noop.result", 32'(bus.result), 32'(exp_res));
            @(negedge clk);
        end

        // Reset at iteration 8 of a MULT.
        bus.alu_op = 3'd3;
        bus.a_in   = 16'd300;
        bus.b_in   = 16'd300;
        @(negedge clk);
        bus.alu_op = 3'd0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_res = 16'h0;
        exp_z   = 1'b1;
        check("rstmul.busy",   32'(bus.busy),   32'd0);
        check("rstmul.result", 32'(bus.result), 32'h0);
        check("rstmul.z",      32'(bus.z),      32'd1);
        check("rstmul.done",   32'(bus.done),   32'd0);
        @(negedge clk);
        check("rstmul.done2",  32'(bus.done),   32'd0);
        do_single(3'd1, 16'd2, 16'd3, "add_after_rst");

        for (int i = 0; i < 30; i++) begin
            rop = 3'($urandom_range(1, 4));
            ra  = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
            rb  = ($urandom_range(0, 7) == 0) ? ra : 16'($urandom);
            if (rop == 3'd3)
                do_mult(ra, rb, -1, "rand_mult");
            else
                do_single(rop, ra, rb, "rand_single");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
